// File: rtl/reg_bank_pkg.sv
// rtl/reg_bank_pkg.sv - shared state encoding, limits and helpers for reg_bank_reader
package reg_bank_pkg;

    localparam int RBR_MAX_N = 256;

    typedef enum logic [1:0] {
        RBR_IDLE = 2'd0,
        RBR_SEND = 2'd1,
        RBR_DONE = 2'd2
    } rbr_state_t;

    // Index width for an n-word bank; a single-word bank still gets a 1-bit index.
    function automatic int idx_width(input int n);
        int m;
        m = (n > RBR_MAX_N) ? RBR_MAX_N : n;
        return (m <= 1) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/reg_bank_snapshot.sv
// rtl/reg_bank_snapshot.sv - N x WIDTH snapshot storage with load enable and indexed read
module reg_bank_snapshot
    import reg_bank_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int N     = 8,
    parameter int IDXW  = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [N*WIDTH-1:0]   bank_in,
    input  logic [IDXW-1:0]      index,
    output logic [WIDTH-1:0]     data
);

    logic [N*WIDTH-1:0] snap;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap <= '0;
        end else if (load) begin
            snap <= bank_in;
        end
    end

    assign data = snap[index*WIDTH +: WIDTH];

endmodule

// File: rtl/reg_bank_reader.sv
// rtl/reg_bank_reader.sv - snapshot a register bank on start and stream it out; READ_CLEAR_EN adds bank_clear
module reg_bank_reader
    import reg_bank_pkg::*;
#(
    parameter  int WIDTH = 16,
    parameter  int N     = 8,
    localparam int IDXW  = idx_width(N)
) (
    input  logic                 clk,
    input  logic                 external_reset,
    input  logic                 start,
    input  logic [N*WIDTH-1:0]   bank_in,
    output logic [WIDTH-1:0]     rd_data,
    output logic [IDXW-1:0]      rd_index,
    output logic                 rd_valid,
    input  logic                 rd_ready,
    output logic                 rd_last,
    output logic                 busy,
    output logic                 done
`ifdef READ_CLEAR_EN
    ,
    output logic                 bank_clear
`endif
);

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

    rbr_state_t      state;
    logic [IDXW-1:0] index;
    logic            load;

    // Capture only from IDLE so a start during a drain never disturbs the snapshot.
    assign load     = (state == RBR_IDLE) && start;
    assign rd_index = index;

    reg_bank_snapshot #(
        .WIDTH (WIDTH),
        .N     (N),
        .IDXW  (IDXW)
    ) u_snapshot (
        .clk     (clk),
        .rst     (external_reset),
        .load    (load),
        .bank_in (bank_in),
        .index   (index),
        .data    (rd_data)
    );

    always_ff @(posedge clk or posedge external_reset) begin
        if (external_reset) begin
            state      <= RBR_IDLE;
            index      <= '0;
            rd_valid   <= 1'b0;
            rd_last    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
`ifdef READ_CLEAR_EN
            bank_clear <= 1'b0;
`endif
        end else begin
            done       <= 1'b0;
`ifdef READ_CLEAR_EN
            bank_clear <= 1'b0;
`endif
            case (state)
                RBR_IDLE: begin
                    if (start) begin
                        state    <= RBR_SEND;
                        index    <= '0;
                        rd_valid <= 1'b1;
                        rd_last  <= (N == 1);
                        busy     <= 1'b1;
                    end
                end
                RBR_SEND: begin
                    if (rd_ready) begin
                        if (rd_last) begin
                            state      <= RBR_DONE;
                            rd_valid   <= 1'b0;
                            rd_last    <= 1'b0;
                            done       <= 1'b1;
`ifdef READ_CLEAR_EN
                            bank_clear <= 1'b1;
`endif
                        end else begin
                            index   <= index + 1'b1;
                            rd_last <= ((index + 1'b1) == LAST_IDX);
                        end
                    end
                end
                RBR_DONE: begin
                    state <= RBR_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state    <= RBR_IDLE;
                    rd_valid <= 1'b0;
                    rd_last  <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_bank_reader.sv
// tb/tb_reg_bank_reader.sv - scoreboard bench for reg_bank_reader (N=4 and N=1 instances)
module tb_reg_bank_reader;

    logic        clk = 1'b0;
    logic        rst;

    logic        start;
    logic [63:0] bank_in;
    logic        rd_ready;
    logic [15:0] rd_data;
    logic [1:0]  rd_index;
    logic        rd_valid, rd_last, busy, done;

    logic        start1;
    logic [15:0] bank1;
    logic        ready1;
    logic [15:0] data1;
    logic [0:0]  index1;
    logic        valid1, last1, busy1, done1;

`ifdef READ_CLEAR_EN
    logic        bank_clear, bank_clear1;
`endif

    int checks = 0;
    int errors = 0;
    int acc_cnt = 0;

    typedef struct {
        logic [15:0] data;
        logic [1:0]  idx;
        logic        last;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;

    reg_bank_reader #(.WIDTH(16), .N(4)) dut (
        .clk            (clk),
        .external_reset (rst),
        .start          (start),
        .bank_in        (bank_in),
        .rd_data        (rd_data),
        .rd_index       (rd_index),
        .rd_valid       (rd_valid),
        .rd_ready       (rd_ready),
        .rd_last        (rd_last),
        .busy           (busy),
        .done           (done)
`ifdef READ_CLEAR_EN
        ,
        .bank_clear     (bank_clear)
`endif
    );

    reg_bank_reader #(.WIDTH(16), .N(1)) dut1 (
        .clk            (clk),
        .external_reset (rst),
        .start          (start1),
        .bank_in        (bank1),
        .rd_data        (data1),
        .rd_index       (index1),
        .rd_valid       (valid1),
        .rd_ready       (ready1),
        .rd_last        (last1),
        .busy           (busy1),
        .done           (done1)
`ifdef READ_CLEAR_EN
        ,
        .bank_clear     (bank_clear1)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Reference model: a drain delivers every word of the captured bank in index order.
    task automatic push_bank(input logic [63:0] bank);
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            e.data = bank[i*16 +: 16];
            e.idx  = 2'(i);
            e.last = (i == 3);
            q.push_back(e);
        end
    endtask

    logic        pend_done = 1'b0;
    logic        hold_valid = 1'b0;
    logic [15:0] hold_data;
    logic [1:0]  hold_idx;

    always @(negedge clk) begin
        if (rst) begin
            pend_done  = 1'b0;
            hold_valid = 1'b0;
        end else begin
            chk("done_timing", done, pend_done);
`ifdef READ_CLEAR_EN
            chk("bank_clear_timing", bank_clear, pend_done);
`endif
            if (pend_done) chk("busy_with_done", busy, 1);
            pend_done = 1'b0;
            if (hold_valid) begin
                chk("hold_valid", rd_valid, 1);
                chk("hold_data", rd_data, hold_data);
                chk("hold_index", rd_index, hold_idx);
            end
            hold_valid = 1'b0;
            if (rd_valid && rd_ready) begin
                if (q.size() == 0) begin
                    fail_now("unexpected_word");
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("rd_data", rd_data, e.data);
                    chk("rd_index", rd_index, e.idx);
                    chk("rd_last", rd_last, e.last);
                    if (e.last) pend_done = 1'b1;
                    acc_cnt++;
                end
            end else if (rd_valid) begin
                hold_valid = 1'b1;
                hold_data  = rd_data;
                hold_idx   = rd_index;
            end
        end
    end

    task automatic start_pulse(input logic [63:0] bank);
        @(posedge clk); #1;
        bank_in = bank;
        start   = 1'b1;
        push_bank(bank);
        @(posedge clk); #1;
        start = 1'b0;
        chk("start_latency_valid", rd_valid, 1);
        chk("start_latency_busy", busy, 1);
    endtask

    task automatic wait_idle(input bit rnd);
        bit ok = 1'b0;
        for (int c = 0; c < 300; c++) begin
            if (!busy) begin
                ok = 1'b1;
                break;
            end
            if (rnd) begin
                rd_ready = 1'($urandom_range(0, 1));
                start    = ($urandom_range(0, 3) == 0);
                bank_in  = {$urandom, $urandom};
            end
            @(posedge clk); #1;
        end
        start    = 1'b0;
        rd_ready = 1'b1;
        if (!ok) fail_now("drain_timeout");
        chk("all_words_delivered", q.size(), 0);
    endtask

    initial begin
        logic [63:0] basic;
        logic        pat [7];
        int          a0;
        bit          seen;

        basic = 64'h0004_0003_0002_0001;
        pat   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

        rst = 1'b1; start = 1'b0; bank_in = '0; rd_ready = 1'b0;
        start1 = 1'b0; bank1 = '0; ready1 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", rd_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_last", rd_last, 0);
        chk("reset_data", rd_data, 0);
        chk("reset_index", rd_index, 0);
        chk("reset_valid_n1", valid1, 0);
`ifdef READ_CLEAR_EN
        chk("reset_bank_clear", bank_clear, 0);
`endif
        rst = 1'b0;

        // Basic drain with continuous ready: words t+1..t+4, done t+5, idle t+6.
        rd_ready = 1'b1;
        start_pulse(basic);
        repeat (3) begin @(posedge clk); #1; end
        chk("last_on_word3", rd_last, 1);
        @(posedge clk); #1;
        chk("done_at_t_n_1", done, 1);
        chk("busy_during_done", busy, 1);
        chk("valid_after_last", rd_valid, 0);
        @(posedge clk); #1;
        chk("busy_falls", busy, 0);
        chk("done_one_cycle", done, 0);
        chk("basic_all_delivered", q.size(), 0);

        // Backpressure pattern.
        start_pulse(basic);
        for (int k = 0; k < 7; k++) begin
            rd_ready = pat[k];
            @(posedge clk); #1;
        end
        wait_idle(1'b0);

        // Snapshot isolation plus an ignored second start.
        rd_ready = 1'b0;
        start_pulse(basic);
        bank_in  = {4{16'hFFFF}};
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        rd_ready = 1'b1;
        wait_idle(1'b0);
        repeat (2) begin @(posedge clk); #1; end
        chk("second_start_ignored", busy, 0);

        // Asynchronous reset mid-drain.
        rd_ready = 1'b1;
        a0 = acc_cnt;
        start_pulse({$urandom, $urandom});
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (acc_cnt >= a0 + 1) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        if (!seen) fail_now("first_word_timeout");
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk("async_rst_valid", rd_valid, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_done", done, 0);
        chk("async_rst_snapshot", rd_data, 0);
        q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        start_pulse({$urandom, $urandom});
        wait_idle(1'b0);

        // Randomized drains with random backpressure, bank churn and stray starts.
        for (int r = 0; r < 20; r++) begin
            start_pulse({$urandom, $urandom});
            wait_idle(1'b1);
        end

        // Single-word bank.
        ready1 = 1'b1;
        bank1  = 16'hBEEF;
        @(posedge clk); #1;
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        chk("n1_valid", valid1, 1);
        chk("n1_last", last1, 1);
        chk("n1_data", data1, 16'hBEEF);
        chk("n1_index", index1, 0);
        chk("n1_done_early", done1, 0);
`ifdef READ_CLEAR_EN
        chk("n1_clear_early", bank_clear1, 0);
`endif
        @(posedge clk); #1;
        chk("n1_done", done1, 1);
        chk("n1_valid_off", valid1, 0);
`ifdef READ_CLEAR_EN
        chk("n1_clear", bank_clear1, 1);
`endif
        @(posedge clk); #1;
        chk("n1_done_off", done1, 0);
        chk("n1_busy_off", busy1, 0);
`ifdef READ_CLEAR_EN
        chk("n1_clear_off", bank_clear1, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
